// File: rtl/morse_decoder.sv
// Morse receiver: samples the line once per unit, classifies marks/spaces by run
// length and decodes letters A..H at each inter-letter gap.
module morse_decoder #(
   parameter int TICK_DIV = 250
) (
   input  logic       ClockIn,
   input  logic       Reset,
   input  logic       DotDashIn,
   output logic [2:0] Letter,
   output logic       LetterValid,
   output logic       Error,
   output logic       Busy
);

   typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

   localparam logic [9:0] TICK_LAST = 10'(TICK_DIV - 1);

   state_t      state, state_nxt;
   logic [9:0]  tcnt;
   logic        tick;
   logic [2:0]  run, run_nxt;
   logic [3:0]  sym, sym_nxt;
   logic [2:0]  nsym, nsym_nxt;
   logic        err, err_nxt;
   logic [2:0]  letter_nxt;
   logic        valid_nxt, error_nxt;
   logic [3:0]  dec;

   // {hit, code}; upper sym bits are zero for short characters
   function automatic logic [3:0] decode(input logic [2:0] n, input logic [3:0] s);
      case ({n, s})
         7'b010_0001: decode = 4'b1_000;
         7'b100_1000: decode = 4'b1_001;
         7'b100_1010: decode = 4'b1_010;
         7'b011_0100: decode = 4'b1_011;
         7'b001_0000: decode = 4'b1_100;
         7'b100_0010: decode = 4'b1_101;
         7'b011_0110: decode = 4'b1_110;
         7'b100_0000: decode = 4'b1_111;
         default:     decode = 4'b0_000;
      endcase
   endfunction

   assign tick = (tcnt == TICK_LAST);
   assign dec  = decode(nsym, sym);

   always_ff @(posedge ClockIn or posedge Reset) begin
      if (Reset) tcnt <= '0;
      else       tcnt <= tick ? '0 : tcnt + 10'd1;
   end

   always_comb begin
      state_nxt  = state;
      run_nxt    = run;
      sym_nxt    = sym;
      nsym_nxt   = nsym;
      err_nxt    = err;
      letter_nxt = Letter;
      valid_nxt  = 1'b0;
      error_nxt  = 1'b0;
      if (tick) begin
         case (state)
            IDLE: begin
               if (DotDashIn) begin
                  state_nxt = MARK;
                  run_nxt   = 3'd1;
                  sym_nxt   = '0;
                  nsym_nxt  = '0;
                  err_nxt   = 1'b0;
               end
            end
            MARK: begin
               if (DotDashIn) begin
                  run_nxt = (run == 3'd7) ? 3'd7 : run + 3'd1;
               end else begin
                  if (run == 3'd1 || run == 3'd3) begin
                     sym_nxt = {sym[2:0], run == 3'd3};
                     if (nsym == 3'd4) err_nxt = 1'b1;
                     if (nsym != 3'd5) nsym_nxt = nsym + 3'd1;
                  end else begin
                     err_nxt = 1'b1;
                  end
                  state_nxt = SPACE;
                  run_nxt   = 3'd1;
               end
            end
            SPACE: begin
               if (DotDashIn) begin
                  if (run == 3'd2) err_nxt = 1'b1;
                  state_nxt = MARK;
                  run_nxt   = 3'd1;
               end else if (run == 3'd2) begin
                  // third space unit closes the character
                  if (err || !dec[3]) begin
                     error_nxt = 1'b1;
                  end else begin
                     letter_nxt = dec[2:0];
                     valid_nxt  = 1'b1;
                  end
                  state_nxt = IDLE;
                  run_nxt   = '0;
                  err_nxt   = 1'b0;
               end else begin
                  run_nxt = run + 3'd1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge ClockIn or posedge Reset) begin
      if (Reset) begin
         state       <= IDLE;
         run         <= '0;
         sym         <= '0;
         nsym        <= '0;
         err         <= 1'b0;
         Letter      <= '0;
         LetterValid <= 1'b0;
         Error       <= 1'b0;
         Busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         run         <= run_nxt;
         sym         <= sym_nxt;
         nsym        <= nsym_nxt;
         err         <= err_nxt;
         Letter      <= letter_nxt;
         LetterValid <= valid_nxt;
         Error       <= error_nxt;
         Busy        <= (state_nxt != IDLE);
      end
   end

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: table vectors, reset corner case and random unit
// streams compared clock-by-clock against a run-length reference model.
module tb_morse_decoder;
   localparam int TD = 4;

   logic       ClockIn = 1'b0;
   logic       Reset;
   logic       DotDashIn;
   logic [2:0] Letter;
   logic       LetterValid, Error, Busy;

   always #5 ClockIn = ~ClockIn;

   morse_decoder #(.TICK_DIV(TD)) dut (
      .ClockIn(ClockIn), .Reset(Reset), .DotDashIn(DotDashIn),
      .Letter(Letter), .LetterValid(LetterValid), .Error(Error), .Busy(Busy)
   );

   int tests = 0, fails = 0;
   int nvalid, nerr;

   // reference model: samples of the current character, decoded by run lengths
   bit         mq[$];
   logic [2:0] m_letter;
   bit         m_busy;
   string      pats[8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

   typedef struct {
      string       name;
      logic [23:0] samp;
      int          n;
      int          exp_v;
      int          exp_e;
      logic [2:0]  exp_letter;
   } vec_t;
   vec_t tbl[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit s, output bit v, output bit e);
      string syms;
      bit    bad, lvl, found;
      int    n, i, len;
      v = 0;
      e = 0;
      if (mq.size() == 0 && !s) return;
      mq.push_back(s);
      n = mq.size();
      if (n >= 3 && !mq[n-1] && !mq[n-2] && !mq[n-3]) begin
         syms = "";
         bad  = 0;
         i    = 0;
         while (i < n - 3) begin
            lvl = mq[i];
            len = 0;
            while (i < n - 3 && mq[i] == lvl) begin
               len++;
               i++;
            end
            if (lvl) begin
               if (len == 1)      syms = {syms, "."};
               else if (len == 3) syms = {syms, "-"};
               else               bad = 1;
            end else if (len != 1) bad = 1;
         end
         if (syms.len() > 4) bad = 1;
         found = 0;
         for (int k = 0; k < 8; k++)
            if (!bad && syms == pats[k]) begin
               found    = 1;
               m_letter = 3'(k);
            end
         if (found) v = 1;
         else       e = 1;
         mq.delete();
      end
   endtask

   // one Morse unit; line is noise except on the sampling (tick) clock
   task automatic unit(input bit s);
      bit v, e;
      for (int c = 0; c < TD; c++) begin
         DotDashIn = (c == TD - 1) ? s : 1'($urandom_range(0, 1));
         @(posedge ClockIn);
         #1;
         v = 0;
         e = 0;
         if (c == TD - 1) begin
            model_step(s, v, e);
            m_busy = (mq.size() != 0);
         end
         if (LetterValid) nvalid++;
         if (Error) nerr++;
         check("outputs{L,V,E,B}", {Letter, LetterValid, Error, Busy}, {m_letter, v, e, m_busy});
         @(negedge ClockIn);
      end
   endtask

   task automatic do_reset();
      #2 Reset = 1'b1;
      #1;
      check("reset_outputs", {Letter, LetterValid, Error, Busy}, 6'b0);
      mq.delete();
      m_letter = '0;
      m_busy   = 0;
      repeat (2) @(negedge ClockIn);
      Reset = 1'b0;
   endtask

   task automatic send_letter(input int k);
      byte ch;
      for (int j = 0; j < pats[k].len(); j++) begin
         if (j > 0) unit(0);
         ch = pats[k][j];
         if (ch == 8'h2D) repeat (3) unit(1);
         else unit(1);
      end
   endtask

   initial begin
      tbl[0]  = '{"A_basic",   24'b10111000,        8, 1, 0, 3'b000};
      tbl[1]  = '{"A",         24'b10111000,        8, 1, 0, 3'b000};
      tbl[2]  = '{"B",         24'b111010101000,   12, 1, 0, 3'b001};
      tbl[3]  = '{"C",         24'b11101011101000, 14, 1, 0, 3'b010};
      tbl[4]  = '{"D",         24'b1110101000,     10, 1, 0, 3'b011};
      tbl[5]  = '{"E",         24'b1000,            4, 1, 0, 3'b100};
      tbl[6]  = '{"F",         24'b101011101000,   12, 1, 0, 3'b101};
      tbl[7]  = '{"G",         24'b111011101000,   12, 1, 0, 3'b110};
      tbl[8]  = '{"H",         24'b1010101000,     10, 1, 0, 3'b111};
      tbl[9]  = '{"bad_mark",  24'b11000,           5, 0, 1, 3'b111};
      tbl[10] = '{"overflow",  24'b101010101000,   12, 0, 1, 3'b111};
      tbl[11] = '{"space2",    24'b1001000,         7, 0, 1, 3'b111};
      tbl[12] = '{"idle",      24'b0,              20, 0, 0, 3'b111};
      tbl[13] = '{"long_tone", 24'b1111111111000,  13, 0, 1, 3'b111};

      Reset     = 1'b1;
      DotDashIn = 1'b0;
      @(negedge ClockIn);
      do_reset();

      for (int i = 0; i < 14; i++) begin
         nvalid = 0;
         nerr   = 0;
         for (int b = tbl[i].n - 1; b >= 0; b--) unit(tbl[i].samp[b]);
         check({tbl[i].name, "_valid_cnt"}, nvalid, tbl[i].exp_v);
         check({tbl[i].name, "_error_cnt"}, nerr, tbl[i].exp_e);
         check({tbl[i].name, "_letter_busy"}, {Letter, Busy}, {tbl[i].exp_letter, 1'b0});
      end

      // reset in the middle of a character discards it silently
      unit(1); unit(0); unit(1);
      do_reset();
      nvalid = 0;
      nerr   = 0;
      unit(1); unit(0); unit(0); unit(0);
      check("post_reset_valid_cnt", nvalid, 1);
      check("post_reset_error_cnt", nerr, 0);
      check("post_reset_letter", Letter, 3'b100);

      for (int it = 0; it < 250; it++) begin
         if ($urandom_range(0, 1) == 1) begin
            send_letter($urandom_range(0, 7));
            repeat (3 + $urandom_range(0, 2)) unit(0);
         end else begin
            repeat ($urandom_range(4, 14)) unit($urandom_range(0, 99) < 45);
         end
      end
      repeat (3) unit(0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/morse_decoder.md
# morse_decoder

- Receive-side stage that consumes the serial Morse stream (DotDashOut) produced by the Lab 5 transmitter and recovers the 3-bit letter code (A–H).
- Samples the line once per Morse unit, classifies dots, dashes and gaps by run length, and decodes each character at its inter-letter gap.
- Pulses LetterValid, or Error for a malformed character.
- Used for loopback checking of the transmitter and for driving a HEX display.

## Interface

Parameters:

- TICK_DIV, default 250: clocks per Morse unit. Matches the transmitter divider period (reload 249 gives a 250-clock period). Legal range is 2..1023.

Ports:

- ClockIn, input, 1: system clock.
- Reset, input, 1: asynchronous, active-high reset.
- DotDashIn, input, 1: serial Morse line (1 = tone). Synchronous to ClockIn and held constant for each unit.
- Letter, output, 3: last decoded letter code. Encoding: A=000, B=001, C=010, D=011, E=100, F=101, G=110, H=111.
- LetterValid, output, 1: one-cycle pulse when Letter is updated.
- Error, output, 1: one-cycle pulse when a character is rejected.
- Busy, output, 1: high while a character is in progress (state is not IDLE).

## Operation

Unit tick:
- tcnt counts 0..TICK_DIV-1 and wraps.
- tick = (tcnt == TICK_DIV-1).
- DotDashIn is sampled only on tick cycles.

Run counter:
- run[2:0] holds the length of the current mark or space in units.
- Saturates at 7.

Symbol register:
- sym[3:0] with the newest symbol in bit 0 (1 = dash).
- nsym[2:0] saturates at 5; a value of 5 means overflow.

Error latch:
- err is cleared on entry to IDLE.

State IDLE:
- Sample 0: stay in IDLE.
- Sample 1: go to MARK. run=1, sym=0, nsym=0, err=0.

State MARK:
- Sample 1: run++ (saturating).
- Sample 0, classify the mark:
  - run==1: shift in a dot.
  - run==3: shift in a dash.
  - Any other run: set err and shift in nothing.
- On any shift-in, nsym++. If nsym was already 4, set err.
- After classifying, go to SPACE with run=1.

State SPACE:
- Sample 1:
  - run==1: go to MARK with run=1 (intra-character gap).
  - run==2: set err, then go to MARK with run=1.
- Sample 0: run++.
  - When run reaches 3, end the character, then go to IDLE.

End of character:
- Decode (nsym, sym):
  - (2, 01) → A
  - (4, 1000) → B
  - (4, 1010) → C
  - (3, 100) → D
  - (1, 0) → E
  - (4, 0010) → F
  - (3, 110) → G
  - (4, 0000) → H
- If err is set or there is no match: pulse Error. Letter is unchanged.
- Otherwise: load Letter and pulse LetterValid.

Other rules:
- The transmitter's trailing zeros and its repeat (rotating) wrap produce repeated characters. Each repeat is decoded and reported again; there is no duplicate suppression.
- LetterValid and Error are never asserted in the same cycle.

## Timing

Reset values:
- Letter=000, LetterValid=0, Error=0, Busy=0.
- tcnt=0, state IDLE, run/sym/nsym/err all 0.

Reset mid-character:
- Asserting Reset immediately clears everything to the reset values.
- The partial character is discarded and no pulse is emitted.

Output timing:
- All outputs are registered.
- LetterValid/Error rise on the clock edge that ends the tick cycle sampling the third space unit. They are high for exactly one clock.
- Busy rises on the edge that ends the tick cycle sampling the first mark unit. It falls on the same edge that LetterValid/Error rise.

Latency:
- From the final mark unit ending to the result pulse is 3 units, i.e. 3·TICK_DIV clocks.

Input changes:
- DotDashIn changes between ticks have no effect. Only tick-cycle samples matter.

## Test plan

All scenarios use TICK_DIV=4; per-unit samples are listed in order.

- **A:** samples 1,0,1,1,1,0,0,0 → LetterValid for one clock after the 8th tick, Letter=000, Error=0. Busy is high from tick 1 through tick 8.
- **All letters:** each transmitter pattern (e.g. B = 111010101000, H = 101010100000, E = 100000000000) applied back-to-back → codes 000..111 in order, eight LetterValid pulses, no Error.
- **Bad mark length:** samples 1,1,0,0,0 (mark of 2 units) → Error pulse after tick 5. No LetterValid; Letter keeps its prior value.
- **Overflow:** five dots (1,0 ×5 then 0,0) → Error at end of character. The same result occurs for a 2-unit space (1,0,0,1,0,0,0).
- **Reset mid-character:** assert Reset after samples 1,0,1 → all outputs 0 immediately. After release, 1,0,0,0 → LetterValid with Letter=100.
- **Idle line:** 20 units of 0 → no LetterValid, no Error, Busy stays 0. A tone longer than 7 units saturates run, then yields Error at the gap.
